// File: rtl/sr_latch_driver.sv
// sr_latch_driver: drives an active-low notS/notR latch with single-sided,
// minimum-width pulses, then reads Q/notQ back through synchronizers to
// confirm the latch took the requested value.
module sr_latch_driver #(
   parameter int PULSE_CYCLES  = 4,   // cycles the selected input is held low (>=1)
   parameter int SETTLE_CYCLES = 2    // idle-high cycles before readback (>=2)
) (
   input  logic clk,
   input  logic rst,
   input  logic set_req,
   input  logic clr_req,
   input  logic q_in,
   input  logic notq_in,
   output logic notS,
   output logic notR,
   output logic busy,
   output logic done,
   output logic error,
   output logic state_q
);

   localparam int MAXC = (PULSE_CYCLES > SETTLE_CYCLES) ? PULSE_CYCLES : SETTLE_CYCLES;
   localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

   typedef enum logic [1:0] {IDLE, PULSE, SETTLE, CHECK} fsmState_t;

   fsmState_t      fsmState;
   logic [CW-1:0]  cnt;
   logic           op;        // 1 = set, 0 = clear
   logic [1:0]     qSync;
   logic [1:0]     notqSync;
   logic           pairOk;

   // Two-flop synchronizers for the asynchronous latch feedback
   always_ff @(posedge clk) begin
      if (rst) begin
         qSync    <= '0;
         notqSync <= '0;
      end else begin
         qSync    <= {qSync[0], q_in};
         notqSync <= {notqSync[0], notq_in};
      end
   end

   // A Q==notQ pair can never equal the expected complementary pair, so a
   // forbidden or metastable latch always shows up as a mismatch.
   assign pairOk = (qSync[1] == op) && (notqSync[1] == ~op);

   // Main sequencer; notS/notR come from a single op bit, so both can never be low
   always_ff @(posedge clk) begin
      if (rst) begin
         fsmState <= IDLE;
         cnt      <= '0;
         op       <= 1'b0;
         notS     <= 1'b1;
         notR     <= 1'b1;
         busy     <= 1'b0;
         done     <= 1'b0;
         error    <= 1'b0;
         state_q  <= 1'b0;
      end else begin
         done  <= 1'b0;
         error <= 1'b0;
         case (fsmState)
            IDLE: begin
               notS <= 1'b1;
               notR <= 1'b1;
               busy <= 1'b0;
               if (set_req && clr_req) begin
                  error <= 1'b1;
               end else if (set_req ^ clr_req) begin
                  op       <= set_req;
                  cnt      <= '0;
                  busy     <= 1'b1;
                  notS     <= ~set_req;
                  notR     <= set_req;
                  fsmState <= PULSE;
               end
            end
            PULSE: begin
               if (cnt == CW'(PULSE_CYCLES - 1)) begin
                  notS     <= 1'b1;
                  notR     <= 1'b1;
                  cnt      <= '0;
                  fsmState <= SETTLE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            SETTLE: begin
               if (cnt == CW'(SETTLE_CYCLES - 1)) begin
                  cnt      <= '0;
                  fsmState <= CHECK;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            CHECK: begin
               state_q  <= qSync[1];
               busy     <= 1'b0;
               done     <= pairOk;
               error    <= ~pairOk;
               fsmState <= IDLE;
            end
            default: begin
               fsmState <= IDLE;
               notS     <= 1'b1;
               notR     <= 1'b1;
               busy     <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sr_latch_driver.sv
// tb_sr_latch_driver: directed vectors against a behavioural latch model,
// with hand-computed timing for the default PULSE_CYCLES=4, SETTLE_CYCLES=2.
module tb_sr_latch_driver;

   logic clk = 1'b0;
   logic rst, set_req, clr_req, q_in, notq_in;
   logic notS, notR, busy, done, error, state_q;

   logic latchQ  = 1'b0;
   logic tieMode = 1'b0;
   logic tieQ    = 1'b0;
   logic tieNq   = 1'b1;

   int nCmp = 0;
   int nBad = 0;

   sr_latch_driver #(.PULSE_CYCLES(4), .SETTLE_CYCLES(2)) dut (
      .clk(clk), .rst(rst), .set_req(set_req), .clr_req(clr_req),
      .q_in(q_in), .notq_in(notq_in), .notS(notS), .notR(notR),
      .busy(busy), .done(done), .error(error), .state_q(state_q)
   );

   always #5 clk = ~clk;

   // Behavioural latch, updated just after each edge from the driven inputs
   always @(posedge clk) begin
      #1;
      if (!notS) latchQ = 1'b1;
      else if (!notR) latchQ = 1'b0;
   end

   assign q_in    = tieMode ? tieQ  : latchQ;
   assign notq_in = tieMode ? tieNq : ~latchQ;

   task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
      nCmp++;
      if (got !== exp) begin
         nBad++;
         $display("FAIL %s: got %0d, want %0d", tag, got, exp);
      end
   endtask

   // Forbidden input pair must never be driven
   always @(negedge clk) chk("noForbid", {7'd0, (!notS && !notR)}, 8'd0);

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   // Issue one op at edge 0 and check edges 0..7
   task automatic runOp(input bit isSet, input bit expOk, input bit expQ, input string nm);
      set_req = isSet;
      clr_req = !isSet;
      tick();
      set_req = 1'b0;
      clr_req = 1'b0;
      for (int e = 0; e <= 7; e++) begin
         if (e > 0) tick();
         chk($sformatf("%s.busy@%0d", nm, e), {7'd0, busy}, {7'd0, (e <= 6)});
         chk($sformatf("%s.sel@%0d", nm, e), {7'd0, (isSet ? notS : notR)}, {7'd0, (e > 3)});
         chk($sformatf("%s.oth@%0d", nm, e), {7'd0, (isSet ? notR : notS)}, 8'd1);
         chk($sformatf("%s.done@%0d", nm, e), {7'd0, done}, {7'd0, (e == 7 && expOk)});
         chk($sformatf("%s.err@%0d", nm, e), {7'd0, error}, {7'd0, (e == 7 && !expOk)});
      end
      chk($sformatf("%s.stateQ", nm), {7'd0, state_q}, {7'd0, expQ});
   endtask

   initial begin
      int nDone;
      rst = 1'b1; set_req = 1'b0; clr_req = 1'b0;
      tick(); tick();
      chk("rst.notS", {7'd0, notS}, 8'd1);
      chk("rst.notR", {7'd0, notR}, 8'd1);
      chk("rst.busy", {7'd0, busy}, 8'd0);
      chk("rst.done", {7'd0, done}, 8'd0);
      chk("rst.err", {7'd0, error}, 8'd0);
      chk("rst.stateQ", {7'd0, state_q}, 8'd0);
      rst = 1'b0;
      tick();

      // 1: set, 2: clear
      runOp(1'b1, 1'b1, 1'b1, "set");
      runOp(1'b0, 1'b1, 1'b0, "clr");

      // 3: both requests together
      set_req = 1'b1; clr_req = 1'b1;
      tick();
      set_req = 1'b0; clr_req = 1'b0;
      chk("both.err", {7'd0, error}, 8'd1);
      chk("both.done", {7'd0, done}, 8'd0);
      chk("both.busy", {7'd0, busy}, 8'd0);
      chk("both.notS", {7'd0, notS}, 8'd1);
      chk("both.notR", {7'd0, notR}, 8'd1);
      tick();
      chk("both.err2", {7'd0, error}, 8'd0);
      chk("both.busy2", {7'd0, busy}, 8'd0);
      chk("both.stateQ", {7'd0, state_q}, 8'd0);

      // 4: latch stuck at Q=0, set must report error
      tieMode = 1'b1; tieQ = 1'b0; tieNq = 1'b1;
      runOp(1'b1, 1'b0, 1'b0, "stuck");
      tieMode = 1'b0;
      tick();

      // 5: set with clr_req held while busy, then clr accepted in done cycle
      set_req = 1'b1;
      tick();
      set_req = 1'b0;
      clr_req = 1'b1;
      nDone = 0;
      for (int e = 1; e <= 7; e++) begin
         if (e == 7) clr_req = 1'b0;
         tick();
         chk($sformatf("drop.notR@%0d", e), {7'd0, notR}, 8'd1);
         chk($sformatf("drop.notS@%0d", e), {7'd0, notS}, {7'd0, (e > 3)});
         chk($sformatf("drop.err@%0d", e), {7'd0, error}, 8'd0);
         if (done) nDone++;
      end
      chk("drop.done7", {7'd0, done}, 8'd1);
      chk("drop.nDone", nDone[7:0], 8'd1);
      chk("drop.stateQ", {7'd0, state_q}, 8'd1);
      clr_req = 1'b1;
      tick();
      clr_req = 1'b0;
      chk("acc.busy", {7'd0, busy}, 8'd1);
      chk("acc.notR", {7'd0, notR}, 8'd0);
      chk("acc.notS", {7'd0, notS}, 8'd1);
      chk("acc.done", {7'd0, done}, 8'd0);
      for (int e = 1; e <= 7; e++) tick();
      chk("acc.done7", {7'd0, done}, 8'd1);
      chk("acc.stateQ", {7'd0, state_q}, 8'd0);
      tick();

      // 6: reset in 2nd PULSE cycle
      set_req = 1'b1;
      tick();
      set_req = 1'b0;
      tick();
      chk("mid.notS1", {7'd0, notS}, 8'd0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("mid.notS", {7'd0, notS}, 8'd1);
      chk("mid.busy", {7'd0, busy}, 8'd0);
      chk("mid.stateQ", {7'd0, state_q}, 8'd0);
      for (int e = 0; e < 8; e++) begin
         tick();
         chk($sformatf("mid.done@%0d", e), {7'd0, done}, 8'd0);
         chk($sformatf("mid.err@%0d", e), {7'd0, error}, 8'd0);
         chk($sformatf("mid.busy@%0d", e), {7'd0, busy}, 8'd0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
      $finish;
   end

endmodule
